// File: rtl/key_enc_pkg.sv
// Shared constants and FSM encoding for the 8-key priority encoder.
// Debounce defaults assume a 50 MHz sys_clk (20 ms qualification window).
package key_enc_pkg;
   localparam int          KEY_NUM     = 8;
   localparam int          CODE_W      = 3;
   localparam int          DEF_CNT_W   = 20;
   localparam logic [19:0] DEF_CNT_MAX = 20'd999_999;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;
endpackage

// File: rtl/key_encoder8_3_prio.sv
// Combinational 8-to-3 priority encoder: highest set index wins, 0 on empty.
// Zero latency; no flow control.
module prio_enc8_3
   import key_enc_pkg::*;
(
   input  logic [KEY_NUM-1:0] i_vec,
   output logic [CODE_W-1:0]  o_code
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      o_code = '0;
      for (int i = 0; i < KEY_NUM; i++) begin
         if (i_vec[i]) o_code = CODE_W'(i);
      end
   end

endmodule

// File: rtl/key_encoder8_3.sv
// Synchronised, debounced 8-key priority encoder with a one-cycle code strobe.
// Press latency 3 + CNT_MAX cycles from key_in edge; no backpressure, one strobe per qualified press.
module key_encoder8_3
   import key_enc_pkg::*;
#(
   parameter int               CNT_W   = DEF_CNT_W,
   parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEF_CNT_MAX)
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [CODE_W-1:0]  code_out,
   output logic               code_valid,
   output logic               key_held
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

   logic [KEY_NUM-1:0] r_sync1;
   logic [KEY_NUM-1:0] r_sync2;
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [KEY_NUM-1:0] r_snap;
   logic [CODE_W-1:0]  r_code;
   logic               r_valid;
   logic               r_held;

   state_t             w_state_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [KEY_NUM-1:0] w_snap_nxt;
   logic [CODE_W-1:0]  w_code_nxt;
   logic               w_valid_nxt;
   logic               w_held_nxt;
   logic [KEY_NUM-1:0] w_press;
   logic               w_any;
   logic               w_cnt_last;
   logic [CODE_W-1:0]  w_snap_code;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_press    = ~r_sync2;
   assign w_any      = |w_press;
   assign w_cnt_last = (r_cnt == CNT_LAST);

   prio_enc8_3 u_prio (
      .i_vec  (r_snap),
      .o_code (w_snap_code)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_snap_nxt  = r_snap;
      w_code_nxt  = r_code;
      w_valid_nxt = 1'b0;
      w_held_nxt  = r_held;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_snap_nxt  = w_press;
               w_cnt_nxt   = '0;
               w_state_nxt = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (!w_any) begin
               w_state_nxt = IDLE;
            end else if (w_press != r_snap) begin
               // Bounce or chord change: restart the window on the new pattern.
               w_snap_nxt = w_press;
               w_cnt_nxt  = '0;
            end else if (w_cnt_last) begin
               w_code_nxt  = w_snap_code;
               w_valid_nxt = 1'b1;
               w_held_nxt  = 1'b1;
               w_state_nxt = HOLD;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            w_held_nxt = 1'b1;
            if (!w_any) begin
               w_cnt_nxt   = '0;
               w_state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (w_any) begin
               w_state_nxt = HOLD;
            end else if (w_cnt_last) begin
               w_held_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_snap  <= '0;
         r_code  <= '0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_snap  <= w_snap_nxt;
         r_code  <= w_code_nxt;
         r_valid <= w_valid_nxt;
         r_held  <= w_held_nxt;
      end
   end

   assign code_out   = r_code;
   assign code_valid = r_valid;
   assign key_held   = r_held;

endmodule

// File: tb/tb_key_encoder8_3.sv
// Directed bench for key_encoder8_3 with CNT_MAX = 4; inputs change on negedge.
module tb_key_encoder8_3;

   logic       sys_clk;
   logic       sys_rst_n;
   logic [7:0] key_in;
   logic [2:0] code_out;
   logic       code_valid;
   logic       key_held;

   int checks;
   int errors;
   int strobes;

   key_encoder8_3 #(.CNT_W(20), .CNT_MAX(20'd4)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key_in     (key_in),
      .code_out   (code_out),
      .code_valid (code_valid),
      .key_held   (key_held)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      #1;
      if (code_valid) strobes++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int         s0;
      logic [7:0] dec;
      checks    = 0;
      errors    = 0;
      strobes   = 0;
      key_in    = 8'hFF;
      sys_rst_n = 1'b0;
      step(3);
      chk("rst_code", 32'(code_out), 32'd0);
      chk("rst_valid", 32'(code_valid), 32'd0);
      chk("rst_held", 32'(key_held), 32'd0);
      sys_rst_n = 1'b1;
      step(3);

      // Clean press of key5
      key_in = 8'hDF;
      step(6);
      chk("k5_valid_early", 32'(code_valid), 32'd0);
      step(1);
      chk("k5_valid", 32'(code_valid), 32'd1);
      chk("k5_code", 32'(code_out), 32'd5);
      chk("k5_held", 32'(key_held), 32'd1);
      step(1);
      chk("k5_valid_one_cycle", 32'(code_valid), 32'd0);
      step(12);
      chk("k5_held_long", 32'(key_held), 32'd1);
      key_in = 8'hFF;
      step(6);
      chk("k5_held_release_early", 32'(key_held), 32'd1);
      step(1);
      chk("k5_held_released", 32'(key_held), 32'd0);
      chk("k5_code_kept", 32'(code_out), 32'd5);
      chk("k5_strobes", 32'(strobes), 32'd1);
      step(3);

      // Reset in the middle of DEBOUNCE for key3
      key_in = 8'hF7;
      step(4);
      #1 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_code", 32'(code_out), 32'd0);
      chk("mid_rst_valid", 32'(code_valid), 32'd0);
      chk("mid_rst_held", 32'(key_held), 32'd0);
      step(1);
      sys_rst_n = 1'b1;
      s0 = strobes;
      step(6);
      chk("k3_no_early_strobe", 32'(strobes - s0), 32'd0);
      step(1);
      chk("k3_valid", 32'(code_valid), 32'd1);
      chk("k3_code", 32'(code_out), 32'd3);
      key_in = 8'hFF;
      step(9);
      chk("k3_released", 32'(key_held), 32'd0);

      // Bounce on key2, then stable low from the final falling edge
      s0 = strobes;
      for (int i = 0; i < 2; i++) begin
         key_in = 8'hFB;
         step(2);
         key_in = 8'hFF;
         step(2);
      end
      key_in = 8'hFB;
      step(6);
      chk("bounce_no_strobe", 32'(strobes - s0), 32'd0);
      step(1);
      chk("bounce_valid", 32'(code_valid), 32'd1);
      chk("bounce_code", 32'(code_out), 32'd2);
      step(5);
      chk("bounce_one_strobe", 32'(strobes - s0), 32'd1);
      key_in = 8'hFF;
      step(9);
      chk("bounce_released", 32'(key_held), 32'd0);

      // Chord key1+key6, then add key7 during HOLD
      s0 = strobes;
      key_in = 8'hBD;
      step(7);
      chk("chord_valid", 32'(code_valid), 32'd1);
      chk("chord_code", 32'(code_out), 32'd6);
      step(2);
      key_in = 8'h3D;
      step(10);
      chk("chord_add_code", 32'(code_out), 32'd6);
      chk("chord_add_held", 32'(key_held), 32'd1);
      chk("chord_one_strobe", 32'(strobes - s0), 32'd1);
      key_in = 8'hFF;
      step(9);
      chk("chord_released", 32'(key_held), 32'd0);

      // Release glitch during HOLD on key4
      s0 = strobes;
      key_in = 8'hEF;
      step(7);
      chk("glitch_code", 32'(code_out), 32'd4);
      step(3);
      key_in = 8'hFF;
      step(2);
      key_in = 8'hEF;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("glitch_held", 32'(key_held), 32'd1);
      end
      key_in = 8'hFF;
      step(9);
      chk("glitch_released", 32'(key_held), 32'd0);
      chk("glitch_one_strobe", 32'(strobes - s0), 32'd1);

      // Every single key through an ideal 3-to-8 decoder
      for (int n = 0; n < 8; n++) begin
         key_in = ~(8'd1 << n);
         step(7);
         chk("single_valid", 32'(code_valid), 32'd1);
         dec = 8'd1 << {code_out[2], code_out[1], code_out[0]};
         chk($sformatf("decode_key%0d", n), 32'(dec), 32'(8'd1 << n));
         key_in = 8'hFF;
         step(9);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
